parity_serdes_gen_chk: RTL

PARITY_SERDES_GEN_CHK -- requirements
Module: parity_serdes_gen_chk

---
 rtl/parity_serdes_gen_chk.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/parity_serdes_gen_chk.sv
// Parity-protected serializer/deserializer: the TX side frames a word as WIDTH data bits
// (LSB first) plus one parity bit; the RX side rebuilds words, flags parity errors and counts them.
module parity_serdes_gen_chk #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             odd_mode,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  output logic             tx_bit,
  output logic             tx_en,
  output logic             tx_done,
  input  logic             rx_en,
  input  logic             rx_bit,
  input  logic             rx_clr,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_err,
  output logic [7:0]       err_cnt
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LastDataIdx = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ParityIdx   = CW'(WIDTH);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_DATA,
    TX_PAR
  } txState_t;

  txState_t         r_txState;
  txState_t         w_txNext;
  logic [WIDTH-1:0] r_txShift;
  logic             r_txAcc;
  logic [CW-1:0]    r_txCnt;

  logic [CW-1:0]    r_rxCnt;
  logic             r_rxAcc;
  logic [WIDTH-1:0] r_rxShift;
  logic [WIDTH-1:0] r_rxData;
  logic             r_rxValid;
  logic             r_rxErr;
  logic [7:0]       r_errCnt;

  logic             w_rxAccIn;
  logic             w_rxAccOut;
  logic             w_rxIsParity;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_txState <= TX_IDLE;
    end else begin
      r_txState <= w_txNext;
    end
  end

  // Outputs decode straight from the state so reset silences the line on the same edge.
  always_comb begin
    w_txNext = r_txState;
    tx_ready = 1'b0;
    tx_en    = 1'b0;
    tx_bit   = 1'b0;
    tx_done  = 1'b0;
    case (r_txState)
      TX_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          w_txNext = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_en  = 1'b1;
        tx_bit = r_txShift[0];
        if (r_txCnt == LastDataIdx) begin
          w_txNext = TX_PAR;
        end
      end
      TX_PAR: begin
        tx_en    = 1'b1;
        tx_bit   = r_txAcc;
        tx_done  = 1'b1;
        w_txNext = TX_IDLE;
      end
      default: begin
        w_txNext = TX_IDLE;
      end
    endcase
  end

  // The word and parity sense are captured only on acceptance, so later input changes cannot leak in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_txShift <= '0;
      r_txAcc   <= 1'b0;
      r_txCnt   <= '0;
    end else begin
      case (r_txState)
        TX_IDLE: begin
          if (tx_valid) begin
            r_txShift <= tx_data;
            r_txAcc   <= odd_mode;
            r_txCnt   <= '0;
          end
        end
        TX_DATA: begin
          r_txShift <= {1'b0, r_txShift[WIDTH-1:1]};
          r_txAcc   <= r_txAcc ^ r_txShift[0];
          r_txCnt   <= r_txCnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign w_rxAccIn    = (r_rxCnt == '0) ? odd_mode : r_rxAcc;
  assign w_rxAccOut   = w_rxAccIn ^ rx_bit;
  assign w_rxIsParity = (r_rxCnt == ParityIdx);

  // Receive framer: a clear beats a simultaneous bit, and idle rx_en cycles simply stall it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rxCnt   <= '0;
      r_rxAcc   <= 1'b0;
      r_rxShift <= '0;
      r_rxData  <= '0;
      r_rxValid <= 1'b0;
      r_rxErr   <= 1'b0;
      r_errCnt  <= '0;
    end else begin
      r_rxValid <= 1'b0;
      if (rx_clr) begin
        r_rxCnt <= '0;
        r_rxAcc <= 1'b0;
      end else if (rx_en) begin
        if (w_rxIsParity) begin
          r_rxData  <= r_rxShift;
          r_rxErr   <= w_rxAccOut;
          r_rxValid <= 1'b1;
          r_rxCnt   <= '0;
          r_rxAcc   <= 1'b0;
          if (w_rxAccOut && (r_errCnt != 8'hFF)) begin
            r_errCnt <= r_errCnt + 8'd1;
          end
        end else begin
          r_rxShift <= {rx_bit, r_rxShift[WIDTH-1:1]};
          r_rxAcc   <= w_rxAccOut;
          r_rxCnt   <= r_rxCnt + 1'b1;
        end
      end
    end
  end

  assign rx_data  = r_rxData;
  assign rx_valid = r_rxValid;
  assign rx_err   = r_rxErr;
  assign err_cnt  = r_errCnt;

endmodule
